// File: rtl/pe_dot_accum_drain.sv
// Receiving end of the PE dot-product adder tree: re-times the beat tags to the tree latency,
// accumulates K-chunk partial sums with saturation, and drains finished sums through a FIFO.
module pe_dot_accum_drain #(
  parameter int DOT_OUTPUT_WIDTH = 20,
  parameter int ACC_WIDTH        = 32,
  parameter int TREE_LATENCY     = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               i_dot_valid,
  input  logic                               i_dot_first,
  input  logic                               i_dot_last,
  input  logic signed [DOT_OUTPUT_WIDTH-1:0] i_tree_result,
  output logic                               o_stall,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic signed [ACC_WIDTH-1:0]        o_data,
  output logic                               o_sat,
  output logic                               o_overflow,
  output logic [15:0]                        o_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EXT_W = ACC_WIDTH + 1 - DOT_OUTPUT_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  typedef struct packed {
    logic                        sat;
    logic signed [ACC_WIDTH-1:0] data;
  } entry_t;

  tag_t                        tag_q [TREE_LATENCY];
  tag_t                        d_tag;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        sat_q, sat_d;
  logic                        open_q, open_d;
  logic signed [ACC_WIDTH:0]   base_x, sum_x;
  logic                        fresh, clip;
  entry_t                      fin;

  entry_t                      mem [FIFO_DEPTH];
  entry_t                      head, hold_q;
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        push_req, push, pop, full;
  logic                        stall_q, overflow_q;
  logic [15:0]                 pop_count_q;

  // Tags are qualified on entry so first/last never leak from an invalid beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TREE_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: i_dot_valid,
                    first: i_dot_valid & i_dot_first,
                    last:  i_dot_valid & i_dot_last};
      for (int i = 1; i < TREE_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign d_tag = tag_q[TREE_LATENCY-1];

  // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latches.
  always_comb begin
    fresh    = d_tag.first | ~open_q;
    base_x   = fresh ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
    sum_x    = base_x + {{EXT_W{i_tree_result[DOT_OUTPUT_WIDTH-1]}}, i_tree_result};
    clip     = sum_x[ACC_WIDTH] ^ sum_x[ACC_WIDTH-1];
    fin.data = clip ? (sum_x[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_x[ACC_WIDTH-1:0];
    fin.sat  = clip | (~fresh & sat_q);
    acc_d    = acc_q;
    sat_d    = sat_q;
    open_d   = open_q;
    if (d_tag.valid) begin
      if (d_tag.last) begin
        acc_d  = '0;
        sat_d  = 1'b0;
        open_d = 1'b0;
      end else begin
        acc_d  = fin.data;
        sat_d  = fin.sat;
        open_d = 1'b1;
      end
    end
  end

  // A pop frees the full slot in the same edge, so push-while-full is honoured then.
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign o_valid  = (count_q != '0);
  assign pop      = o_valid & i_ready;
  assign push_req = d_tag.valid & d_tag.last;
  assign push     = push_req & (~full | pop);
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign head     = mem[rd_ptr_q];

  // When empty the last popped entry is shown, so o_data holds its value.
  assign o_data     = o_valid ? head.data : hold_q.data;
  assign o_sat      = o_valid ? head.sat  : hold_q.sat;
  assign o_stall    = stall_q;
  assign o_overflow = overflow_q;
  assign o_count    = pop_count_q;

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      sat_q       <= 1'b0;
      open_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      stall_q     <= 1'b0;
      overflow_q  <= 1'b0;
      pop_count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      open_q  <= open_d;
      count_q <= count_d;
      // Free slots must cover every beat still travelling through the delay line.
      stall_q <= (CNT_W'(FIFO_DEPTH) - count_d) <= CNT_W'(TREE_LATENCY + 1);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        hold_q      <= head;
        pop_count_q <= pop_count_q + 16'd1;
      end
      if (push_req & full & ~pop) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= fin;
  end

endmodule
